ccc_apb_reconfig: RTL

- APB initiator for the dynamic-configuration port of the FCCC/CCC clock conditioning block; the CCC port is the responder.
- Accepts single read/write/commit requests from a host-side valid/ready interface and runs fixed two-phase APB accesses; the CCC port has no PREADY.
- Commit pulses the PLL reset and waits for LOCK with a timeout, so configuration bytes take effect.
- Sits beside the FCCC wrapper in the fabric.

---
 rtl/ccc_reconfig_pkg.sv | 22 ++
 rtl/ccc_lock_sync.sv | 33 +++
 rtl/ccc_apb_reconfig.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ccc_reconfig_pkg.sv
// Shared opcodes, FSM state encoding and default bus widths for the CCC
// dynamic-configuration APB initiator.
package ccc_reconfig_pkg;

   localparam int CCC_ADDR_W = 6;
   localparam int CCC_DATA_W = 8;

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;
   localparam logic [1:0] OP_RSVD   = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      ACCESS   = 3'd2,
      RESP     = 3'd3,
      PLLRST   = 3'd4,
      LOCKWAIT = 3'd5
   } state_e;

endpackage

// File: rtl/ccc_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous CCC LOCK into the PCLK domain.
module ccc_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next values: the first stage samples the raw input, the second the first.
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Synchronizer stages, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/ccc_apb_reconfig.sv
// APB initiator for the FCCC/CCC dynamic-configuration port. Runs single
// read/write accesses (fixed SETUP/ACCESS, no PREADY on the responder) and a
// commit sequence that pulses the PLL reset and waits for LOCK with a timeout.
//
// Host handshake: a request is taken on the PCLK edge where REQ_VALID and
// REQ_READY are both high; REQ_READY is high only while the FSM is idle, so
// request inputs are ignored while BUSY. Exactly one RSP_VALID pulse follows
// every accepted request (unless PRESET aborts it) and the host must take it
// in that cycle, since there is no response backpressure.
module ccc_apb_reconfig import ccc_reconfig_pkg::*; #(
   parameter int RST_CYCLES   = 8,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int ADDR_W       = CCC_ADDR_W,
   parameter int DATA_W       = CCC_DATA_W
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic [1:0]        REQ_OP,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              RSP_VALID,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   output logic              PLL_ARST_N,
   input  logic              LOCK,
   output logic              LOCKED,
   output logic              BUSY
);

   // Counters are sized to hold their terminal value so they never wrap.
   localparam int RST_W  = $clog2(RST_CYCLES + 1);
   localparam int LOCK_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT);

   state_e              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                busy_q, busy_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                pll_arst_n_q, pll_arst_n_d;
   logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
   logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [LOCK_W-1:0]   lock_cnt_inc;
   logic                locked_sync;

   ccc_lock_sync u_lock_sync (
      .clk      (PCLK),
      .rst      (PRESET),
      .async_in (LOCK),
      .sync_out (locked_sync)
   );

   assign lock_cnt_inc = lock_cnt_q + LOCK_W'(1);

   // Next-state and next-output logic; every output is the flop of its _d value.
   always_comb begin
      state_d      = state_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      rsp_rdata_d  = '0;
      pll_arst_n_d = pll_arst_n_q;
      rst_cnt_d    = rst_cnt_q;
      lock_cnt_d   = lock_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               case (REQ_OP)
                  OP_READ, OP_WRITE: begin
                     state_d   = SETUP;
                     psel_d    = 1'b1;
                     penable_d = 1'b0;
                     pwrite_d  = (REQ_OP == OP_WRITE);
                     paddr_d   = REQ_ADDR;
                     pwdata_d  = REQ_WDATA;
                  end
                  OP_COMMIT: begin
                     state_d      = PLLRST;
                     pll_arst_n_d = 1'b0;
                     rst_cnt_d    = RST_W'(1);
                  end
                  default: begin
                     // Reserved opcode: answer with an error, touch nothing.
                     state_d     = RESP;
                     rsp_valid_d = 1'b1;
                     rsp_err_d   = 1'b1;
                  end
               endcase
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // PRDATA is taken at the end of the enable phase; writes return 0.
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? '0 : PRDATA;
         end
         RESP: begin
            state_d = IDLE;
         end
         PLLRST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d      = LOCKWAIT;
               pll_arst_n_d = 1'b1;
               lock_cnt_d   = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end
         LOCKWAIT: begin
            // A lock seen in the final wait cycle still counts as success.
            if (locked_sync) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
            end else if (lock_cnt_inc == LOCK_LAST) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               lock_cnt_d  = lock_cnt_inc;
            end else begin
               lock_cnt_d = lock_cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and registered outputs; PRESET aborts any sequence in progress.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
         pll_arst_n_q <= 1'b1;
         rst_cnt_q    <= '0;
         lock_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
         pll_arst_n_q <= pll_arst_n_d;
         rst_cnt_q    <= rst_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end

   assign REQ_READY  = req_ready_q;
   assign BUSY       = busy_q;
   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_ERR    = rsp_err_q;
   assign RSP_RDATA  = rsp_rdata_q;
   assign PLL_ARST_N = pll_arst_n_q;
   assign LOCKED     = locked_sync;

endmodule
